// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM states, entry layout
// and the base-frequency table (octave code 0 = 4th octave, integer Hz).
package note_seq_pkg;

  localparam int NOTE_W    = 4;
  localparam int OCT_W     = 2;
  localparam int NUM_TONES = 12;

  localparam logic [NOTE_W-1:0] REST_CODE = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
  } note_entry_t;

  // C, C#, D, D#, E, F, F#, G, G#, A, A#, B
  localparam logic [15:0] BASE_FREQ [NUM_TONES] = '{
    16'd262, 16'd277, 16'd294, 16'd311, 16'd330, 16'd349,
    16'd370, 16'd392, 16'd415, 16'd440, 16'd466, 16'd494
  };

endpackage

// File: rtl/note_sequencer_if.sv
// Record/playback bus of the note sequencer; master = controller, slave = sequencer.
interface note_sequencer_if
  import note_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int FREQ_W = 32
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // A record transfer happens on a rising edge where rec_valid & rec_ready are both 1;
  // rec_valid may be raised or dropped at any time, rec_ready never waits on rec_valid.
  logic                clear;
  logic                rec_valid;
  logic [NOTE_W-1:0]   rec_note;
  logic [OCT_W-1:0]    rec_octave;
  logic                rec_ready;
  logic                play_start;
  logic                play_stop;
  logic                loop_en;

  logic [FREQ_W-1:0]   freq_out;
  logic [NOTE_W-1:0]   cur_note;
  logic [OCT_W-1:0]    cur_octave;
  logic                note_valid;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;
  logic                playing;
  logic                done;
  seq_state_e          state_dbg;

  modport master (
    output clear, rec_valid, rec_note, rec_octave, play_start, play_stop, loop_en,
    input  rec_ready, freq_out, cur_note, cur_octave, note_valid, count,
           full, empty, playing, done, state_dbg
  );

  modport slave (
    input  clear, rec_valid, rec_note, rec_octave, play_start, play_stop, loop_en,
    output rec_ready, freq_out, cur_note, cur_octave, note_valid, count,
           full, empty, playing, done, state_dbg
  );

endinterface

// File: rtl/seq_freq_lut.sv
// Stateless {octave,note} -> frequency map; codes 12..15 map to 0 (silent).
module seq_freq_lut
  import note_seq_pkg::*;
#(
  parameter int FREQ_W = 32
) (
  input  logic [OCT_W-1:0]  octave,
  input  logic [NOTE_W-1:0] note,
  output logic [FREQ_W-1:0] freq
);

  logic [15:0] base;

  always_comb begin
    base = '0;
    if (note < NOTE_W'(NUM_TONES)) begin
      base = BASE_FREQ[note];
    end
    freq = FREQ_W'(base) << octave;
  end

endmodule

// File: rtl/note_sequencer.sv
// Records up to DEPTH notes and plays them back, each held TICK_DIV clocks.
// Optional: define NOTE_SEQ_REST_EN to accept code 15 as a timed rest.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 12500000,
  parameter int FREQ_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  note_sequencer_if.slave   bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  seq_state_e          state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                end_q, end_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [NOTE_W-1:0]   cur_note_q, cur_note_d;
  logic [OCT_W-1:0]    cur_oct_q, cur_oct_d;
  logic                note_valid_q, note_valid_d;
  logic                done_q, done_d;

  note_entry_t         mem_q [DEPTH];
  note_entry_t         rd_entry;
  logic [FREQ_W-1:0]   lut_freq;
  logic                full;
  logic                note_ok;
  logic                rec_ready;
  logic                rec_fire;
  logic                last_entry;

`ifdef NOTE_SEQ_REST_EN
  assign note_ok = 1'b1;
`else
  assign note_ok = (bus.rec_note != REST_CODE);
`endif

  assign full       = (count_q == CNT_FULL);
  assign rec_ready  = (state_q == ST_IDLE) & ~full & ~bus.play_start & ~bus.clear & note_ok;
  assign rec_fire   = bus.rec_valid & rec_ready;
  assign rd_entry   = mem_q[rd_ptr_q];
  assign last_entry = (rd_ptr_q == PTR_W'(count_q - 1'b1));

  seq_freq_lut #(.FREQ_W(FREQ_W)) u_lut (
    .octave (rd_entry.octave),
    .note   (rd_entry.note),
    .freq   (lut_freq)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hold_d       = hold_q;
    end_d        = end_q;
    freq_d       = freq_q;
    cur_note_d   = cur_note_q;
    cur_oct_d    = cur_oct_q;
    note_valid_d = note_valid_q;
    done_d       = 1'b0;

    if (bus.clear) begin
      state_d      = ST_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      hold_d       = '0;
      end_d        = 1'b0;
      freq_d       = '0;
      cur_note_d   = '0;
      cur_oct_d    = '0;
      note_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.play_start && (count_q != '0)) begin
            state_d  = ST_PLAY;
            rd_ptr_d = '0;
            hold_d   = '0;
            end_d    = 1'b0;
          end else if (rec_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
        end

        ST_PLAY: begin
          if (bus.play_stop || end_q) begin
            // end_q gives the last entry its full hold time behind the registered lookup
            state_d      = ST_IDLE;
            done_d       = end_q & ~bus.play_stop;
            end_d        = 1'b0;
            freq_d       = '0;
            cur_note_d   = '0;
            cur_oct_d    = '0;
            note_valid_d = 1'b0;
          end else begin
            freq_d       = lut_freq;
            cur_note_d   = rd_entry.note;
            cur_oct_d    = rd_entry.octave;
            note_valid_d = 1'b1;
            if (hold_q == HOLD_LAST) begin
              hold_d = '0;
              if (!last_entry) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
              end else if (bus.loop_en) begin
                rd_ptr_d = '0;
              end else begin
                end_d = 1'b1;
              end
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= '0;
      end_q        <= 1'b0;
      freq_q       <= '0;
      cur_note_q   <= '0;
      cur_oct_q    <= '0;
      note_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      end_q        <= end_d;
      freq_q       <= freq_d;
      cur_note_q   <= cur_note_d;
      cur_oct_q    <= cur_oct_d;
      note_valid_q <= note_valid_d;
      done_q       <= done_d;
    end
  end

  // Storage keeps its contents across reset and clear; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (reset && rec_fire) begin
      mem_q[wr_ptr_q] <= '{octave: bus.rec_octave, note: bus.rec_note};
    end
  end

  assign bus.rec_ready  = rec_ready;
  assign bus.freq_out   = freq_q;
  assign bus.cur_note   = cur_note_q;
  assign bus.cur_octave = cur_oct_q;
  assign bus.note_valid = note_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = (count_q == '0);
  assign bus.playing    = (state_q == ST_PLAY);
  assign bus.done       = done_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with DEPTH=4, TICK_DIV=3; inputs driven and
// outputs sampled on the falling edge.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 3;
  localparam int FREQ_W   = 32;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [FREQ_W-1:0] exp_q[$];

  note_sequencer_if #(.DEPTH(DEPTH), .FREQ_W(FREQ_W)) bus ();

  note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .FREQ_W(FREQ_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic rec(input logic [3:0] n, input logic [1:0] o, input logic acc, input string tag);
    bus.rec_valid  = 1'b1;
    bus.rec_note   = n;
    bus.rec_octave = o;
    #1;
    check(tag, 64'(bus.rec_ready), 64'(acc));
    @(negedge clk);
    bus.rec_valid = 1'b0;
  endtask

  task automatic start_play(input logic lp);
    bus.play_start = 1'b1;
    bus.loop_en    = lp;
    @(negedge clk);
    bus.play_start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    bus.clear      = 1'b0;
    bus.rec_valid  = 1'b0;
    bus.rec_note   = '0;
    bus.rec_octave = '0;
    bus.play_start = 1'b0;
    bus.play_stop  = 1'b0;
    bus.loop_en    = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_state", 64'(bus.state_dbg), 64'(ST_IDLE));
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_freq", 64'(bus.freq_out), 64'd0);
    check("rst_valid", 64'(bus.note_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    reset = 1'b1;
    @(negedge clk);

    // fill: 5 back-to-back, 5th refused
    for (int i = 0; i < 5; i++) begin
      rec(4'(i), 2'd0, (i < 4), $sformatf("fill_ready_%0d", i));
    end
    check("fill_count", 64'(bus.count), 64'd4);
    check("fill_full", 64'(bus.full), 64'd1);
    do_clear();
    check("clr_count", 64'(bus.count), 64'd0);
    check("clr_empty", 64'(bus.empty), 64'd1);

    // C4 E4 G4, no loop
    rec(4'd0, 2'd0, 1'b1, "p1_rec_c");
    rec(4'd4, 2'd0, 1'b1, "p1_rec_e");
    rec(4'd7, 2'd0, 1'b1, "p1_rec_g");
    repeat (3) exp_q.push_back(32'd262);
    repeat (3) exp_q.push_back(32'd330);
    repeat (3) exp_q.push_back(32'd392);
    start_play(1'b0);
    check("p1_c0_playing", 64'(bus.playing), 64'd1);
    check("p1_c0_valid", 64'(bus.note_valid), 64'd0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("p1_valid_c%0d", c), 64'(bus.note_valid), 64'd1);
      check($sformatf("p1_freq_c%0d", c), 64'(bus.freq_out), 64'(exp_q.pop_front()));
      check($sformatf("p1_nodone_c%0d", c), 64'(bus.done), 64'd0);
      if (c == 4) check("p1_cur_note_c4", 64'(bus.cur_note), 64'd4);
    end
    @(negedge clk);
    check("p1_done", 64'(bus.done), 64'd1);
    check("p1_end_valid", 64'(bus.note_valid), 64'd0);
    check("p1_end_freq", 64'(bus.freq_out), 64'd0);
    check("p1_end_playing", 64'(bus.playing), 64'd0);
    @(negedge clk);
    check("p1_done_once", 64'(bus.done), 64'd0);

    // same sequence looped, stopped at cycle 14
    for (int k = 0; k < 2; k++) begin
      repeat (3) exp_q.push_back(32'd262);
      repeat (3) exp_q.push_back(32'd330);
      repeat (3) exp_q.push_back(32'd392);
    end
    start_play(1'b1);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check($sformatf("p2_valid_c%0d", c), 64'(bus.note_valid), 64'd1);
      check($sformatf("p2_freq_c%0d", c), 64'(bus.freq_out), 64'(exp_q.pop_front()));
    end
    exp_q.delete();
    bus.play_stop = 1'b1;
    @(negedge clk);
    bus.play_stop = 1'b0;
    bus.loop_en   = 1'b0;
    check("p2_stop_valid", 64'(bus.note_valid), 64'd0);
    check("p2_stop_freq", 64'(bus.freq_out), 64'd0);
    check("p2_stop_state", 64'(bus.state_dbg), 64'(ST_IDLE));
    for (int c = 0; c < 3; c++) begin
      check($sformatf("p2_nodone_%0d", c), 64'(bus.done), 64'd0);
      @(negedge clk);
    end

    // play_start while empty
    do_clear();
    start_play(1'b0);
    check("emp_playing", 64'(bus.playing), 64'd0);
    check("emp_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    check("emp_done2", 64'(bus.done), 64'd0);

    // play_start beats a simultaneous record
    rec(4'd0, 2'd0, 1'b1, "pr_rec_c");
    bus.rec_valid  = 1'b1;
    bus.rec_note   = 4'd4;
    bus.play_start = 1'b1;
    #1;
    check("pr_ready_low", 64'(bus.rec_ready), 64'd0);
    @(negedge clk);
    bus.rec_valid  = 1'b0;
    bus.play_start = 1'b0;
    check("pr_playing", 64'(bus.playing), 64'd1);
    check("pr_count", 64'(bus.count), 64'd1);
    repeat (3) @(negedge clk);
    check("pr_c3_freq", 64'(bus.freq_out), 64'd262);
    @(negedge clk);
    check("pr_single_done", 64'(bus.done), 64'd1);

    // reset mid-playback
    start_play(1'b0);
    @(negedge clk);
    check("mr_valid", 64'(bus.note_valid), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mr_state", 64'(bus.state_dbg), 64'(ST_IDLE));
    check("mr_count", 64'(bus.count), 64'd0);
    check("mr_freq", 64'(bus.freq_out), 64'd0);
    check("mr_note", 64'(bus.cur_note), 64'd0);
    check("mr_valid0", 64'(bus.note_valid), 64'd0);
    check("mr_done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // clear mid-playback, second entry one octave up
    rec(4'd0, 2'd0, 1'b1, "mc_rec_c");
    rec(4'd4, 2'd1, 1'b1, "mc_rec_e5");
    start_play(1'b0);
    repeat (4) @(negedge clk);
    check("mc_freq_e5", 64'(bus.freq_out), 64'd660);
    check("mc_note_e5", 64'(bus.cur_note), 64'd4);
    check("mc_oct_e5", 64'(bus.cur_octave), 64'd1);
    do_clear();
    check("mc_state", 64'(bus.state_dbg), 64'(ST_IDLE));
    check("mc_count", 64'(bus.count), 64'd0);
    check("mc_freq", 64'(bus.freq_out), 64'd0);
    check("mc_note", 64'(bus.cur_note), 64'd0);
    check("mc_oct", 64'(bus.cur_octave), 64'd0);
    check("mc_valid", 64'(bus.note_valid), 64'd0);
    check("mc_done", 64'(bus.done), 64'd0);

    // codes 13 and 15
    rec(4'd13, 2'd2, 1'b1, "rs_rec_13");
`ifdef NOTE_SEQ_REST_EN
    rec(4'd15, 2'd0, 1'b1, "rs_rec_15");
    check("rs_count", 64'(bus.count), 64'd2);
    start_play(1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("rs_valid_c%0d", c), 64'(bus.note_valid), 64'd1);
      check($sformatf("rs_freq_c%0d", c), 64'(bus.freq_out), 64'd0);
      check($sformatf("rs_note_c%0d", c), 64'(bus.cur_note), (c <= 3) ? 64'd13 : 64'd15);
    end
`else
    rec(4'd15, 2'd0, 1'b0, "rs_rej_15");
    @(negedge clk);
    check("rs_count", 64'(bus.count), 64'd1);
    start_play(1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("rs_valid_c%0d", c), 64'(bus.note_valid), 64'd1);
      check($sformatf("rs_freq_c%0d", c), 64'(bus.freq_out), 64'd0);
      check($sformatf("rs_note_c%0d", c), 64'(bus.cur_note), 64'd13);
    end
`endif
    @(negedge clk);
    check("rs_done", 64'(bus.done), 64'd1);
    check("rs_end_valid", 64'(bus.note_valid), 64'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: note storage entries, power of two, 2..256.
REQ-002 Parameter TICK_DIV, default 12500000: clk cycles each note is held during playback, >=1.
REQ-003 Parameter FREQ_W, default 32: freq_out width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 clear  in  1  empties storage; returns to IDLE.
REQ-007 rec_valid  in  1  record request.
REQ-008 rec_note  in  4  note code 0..11; 15 = rest.
REQ-009 rec_octave  in  2  octave.
REQ-010 rec_ready  out  1  record accepted when rec_valid & rec_ready.
REQ-011 play_start  in  1  start playback.
REQ-012 play_stop  in  1  abort playback.
REQ-013 loop_en  in  1  restart from entry 0 after the last entry.
REQ-014 freq_out  out  FREQ_W  current tone frequency; 0 = silent.
REQ-015 cur_note / cur_octave  out  4 / 2  entry currently playing.
REQ-016 note_valid  out  1  cur_* and freq_out are valid.
REQ-017 count  out  $clog2(DEPTH)+1  stored entries.
REQ-018 full / empty / playing / done  out  1  count==DEPTH / count==0 / state==PLAY / one-cycle end-of-sequence pulse.

Function
REQ-019 States IDLE, PLAY; all state, pointer and output registers are updated on the clk edge.
REQ-020 rec_ready = (state==IDLE) & !full & !play_start & !clear (combinational).
REQ-021 On an accepted record: store {rec_octave,rec_note} at wr_ptr; wr_ptr and count increment by 1. Requests while rec_ready=0 are dropped and leave no side effect.
REQ-022 play_start in IDLE with count>0: enter PLAY; rd_ptr=0; hold counter=0. With count==0 it is ignored and done is not pulsed.
REQ-023 In PLAY: freq_out, cur_*, and note_valid=1 reflect entry rd_ptr one cycle after rd_ptr changes (registered lookup).
REQ-024 Each entry is held exactly TICK_DIV cycles; rd_ptr then advances.
REQ-025 After entry count-1: if loop_en, rd_ptr=0 and PLAY continues with no gap; otherwise go to IDLE, pulse done for 1 cycle, and drive note_valid=0, freq_out=0.
REQ-026 play_stop in PLAY: go to IDLE next edge; note_valid=0, freq_out=0; no done pulse.
REQ-027 Priority: reset > clear > play_stop > play_start > record.
REQ-028 clear: count=0, wr_ptr=0, state=IDLE, outputs silent; storage contents are don't-care.
REQ-029 freq_out is 0 for any note code 12..15 unless REQ-035 applies.

Reset
REQ-030 While reset=0: state=IDLE, wr_ptr=rd_ptr=count=0, freq_out=0, cur_note=0, cur_octave=0, note_valid=0, done=0; this also applies mid-playback.
REQ-031 Storage array is not reset.

Configuration
REQ-032 Macro NOTE_SEQ_REST_EN.
REQ-033 Defined: code 15 is a rest; it plays for TICK_DIV cycles with note_valid=1, freq_out=0, cur_note=15.
REQ-034 Undefined: code 15 is rejected at record (rec_ready=0 when rec_note==15).
REQ-035 In both cases, codes 12..14 record normally and play as freq_out=0.

Structure
REQ-036 Package note_seq_pkg holds: state enum, NOTE_W=4, OCT_W=2, REST_CODE=4'd15, 12-entry base-frequency constant table.
REQ-037 One sub-module, seq_freq_lut: combinational {octave,note} -> FREQ_W frequency (base << octave); it has no state.

Verification (DEPTH=4, TICK_DIV=3)
REQ-038 Record 5 notes back-to-back -> first 4 accepted, full=1, count=4, rec_ready=0 on the 5th.
REQ-039 Record C4,E4,G4, then play_start, loop_en=0 -> each note valid for 3 cycles, starting 1 cycle after start; done pulses once after 9 cycles; then freq_out=0.
REQ-040 Same sequence with loop_en=1 -> C4 follows G4 with no gap; play_stop at cycle 14 -> silent next cycle, done stays 0.
REQ-041 play_start with empty=1 -> state stays IDLE, no done pulse; play_start and rec_valid in the same cycle -> playback starts and the record is dropped.
REQ-042 reset=0 mid-PLAY and clear mid-PLAY -> IDLE, count=0 (clear), all outputs at REQ-030 values next cycle.
REQ-043 Record code 15, once with NOTE_SEQ_REST_EN defined and once undefined -> a 3-cycle silent valid slot vs. record rejected.
